pool_writeback: RTL and testbench
=================================

Name: pool_writeback

Overview:
- Downstream of the 2x2 max-pool stage. Consumes one pooled int8 sample per cycle, tagged with its pre-pool block-origin row/col.
- Converts the tag to a byte address in the activation buffer, buffers it in a small FIFO, and coalesces bytes that share a 32-bit word.
- Issues word writes with byte enables on a valid/ready memory port.
- The pool stage has no backpressure, so this block absorbs stalls and flags overflow.

Parameters:
- N_BITS, 10, width of row/col coordinates and of cfg_out_w/cfg_out_h.
- FILTER_H, 2, pooling window height; power of two, enforced by elaboration assertion.
- FILTER_W, 2, pooling window width; power of two.
- ADDR_W, 16, byte-address width.
- FIFO_DEPTH, 8, entry FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  per-layer sync clear of count/overflow/done
- cfg_base_addr  in  ADDR_W  byte base address of output plane
- cfg_out_w  in  N_BITS  pooled plane width
- cfg_out_h  in  N_BITS  pooled plane height
- cfg_total  in  ADDR_W  expected pooled pixels for the layer
- in_valid  in  1  pooled sample valid
- in_row  in  N_BITS  pre-pool row of block origin
- in_col  in  N_BITS  pre-pool col of block origin
- in_data  in  8  signed int8 sample
- mem_req_valid  out  1  write request valid
- mem_req_ready  in  1  memory accepts
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  write data, byte lane k = bits 8k+7:8k
- mem_be  out  4  byte enables
- overflow  out  1  sticky: sample dropped on full FIFO
- busy  out  1  stage1 valid | FIFO non-empty | state != IDLE
- done  out  1  one-cycle pulse when written count reaches cfg_total
- oob_err  out  1  sticky: out-of-bounds sample dropped (only with macro)

Behaviour:
- reset (asynchronous, active-high) clears every output, FIFO pointers, count and state to 0 / IDLE.
- Stage 1 (registered, 1 cycle):
  - pr = in_row / FILTER_H and pc = in_col / FILTER_W, computed as shifts.
  - byte_addr = cfg_base_addr + pr*cfg_out_w + pc, truncated to ADDR_W; wraps modulo 2^ADDR_W.
  - Entry pushed to FIFO: {byte_addr[ADDR_W-1:2], lane = byte_addr[1:0], data}.
- FIFO push occurs the cycle after in_valid.
- Push when full with no pop that cycle: entry dropped; overflow set until start or reset.
- Push when full with a simultaneous pop: push is accepted.
- Pending register holds {waddr, be, wdata}. FSM:
  - IDLE: if FIFO non-empty, pop head into pending (be = one-hot lane) -> ACCUM.
  - ACCUM: if FIFO non-empty, head waddr == pending waddr, and the head lane is not yet in be: merge, pop, stay. Otherwise -> ISSUE. If be becomes 4'hF -> ISSUE immediately.
  - ISSUE: mem_req_valid=1; addr/wdata/be held stable until mem_req_ready. On handshake: if FIFO non-empty, pop head into pending -> ACCUM; else -> IDLE.
- Lane collision (same word, lane already set) never overwrites; it forces ISSUE, and the colliding entry starts the next word.
- mem_wdata lanes not set in be are driven 0.
- Minimum latency in_valid -> mem_req_valid is 4 cycles: stage1, FIFO, ACCUM, ISSUE.
- Written count increments by popcount(be) on each handshake.
- done pulses on the handshake where count first becomes >= cfg_total.
- cfg_total = 0: done never pulses.
- start clears count, overflow, oob_err and done only; in-flight data still drains and is counted. start is legal only when busy=0; otherwise the count is undefined.
- cfg_* must be stable while busy=1.

Optional Feature:
- Macro POOL_WB_BOUNDS_CHECK_EN.
- Defined: in stage 1, a sample with pr >= cfg_out_h or pc >= cfg_out_w is not pushed, and sticky oob_err is set (cleared by start/reset).
- Undefined: no check, oob_err port absent, cfg_out_h unused; addresses simply wrap.

Test Plan:
- base=0x100, out_w=4, ready=1; samples (0,0)=5, (0,2)=-3 back-to-back -> one write addr 0x40, be=4'b0011, wdata=0x0000FD05.
- out_w=4; samples (0,0),(0,2),(2,0),(2,2) consecutive -> writes 0x40 be=0011 then 0x41 be=0011. With cfg_total=4: done pulses on the 2nd handshake.
- mem_req_ready=0 for 20 cycles; 12 samples to distinct words -> 8 buffered plus pending, later pushes dropped, overflow=1. The held request keeps addr/be stable. start after drain clears overflow.
- Two samples with the same coords back-to-back -> two separate writes of the same be; no merge.
- base=0xFFFE, out_w=4; sample (0,4) -> byte_addr wraps to 0x0000, mem_addr=0, be=0001.
- With POOL_WB_BOUNDS_CHECK_EN, out_w=4, out_h=4; sample (0,8) -> no write, oob_err=1. Without the macro -> write at word of base+4.

Source files
------------

// File: rtl/pool_writeback.sv
// pool_writeback: turns tagged pooled int8 samples into coalesced word writes.
// Optional bounds check on the pooled coords: define POOL_WB_BOUNDS_CHECK_EN.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               per-layer clear of written count, overflow, oob_err, done
//   cfg_base_addr       byte base address of the output plane
//   cfg_out_w/out_h     pooled plane width / height (height used by bounds check)
//   cfg_total           pooled pixels expected for the layer
//   in_valid/row/col/   pooled sample, tagged with the pre-pool block origin
//   in_data
//   mem_req_*           word write request: valid/ready, word address,
//   mem_addr/wdata/be   32-bit data, byte enables (unused lanes are 0)
//   overflow            sticky, a sample was dropped on a full FIFO
//   busy                stage 1, FIFO or write FSM still holds data
//   done                one-cycle pulse once the written count reaches cfg_total
//   oob_err             sticky, an out-of-bounds sample was dropped (macro only)
module pool_writeback #(
    parameter int N_BITS     = 10,
    parameter int FILTER_H   = 2,
    parameter int FILTER_W   = 2,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [N_BITS-1:0]   cfg_out_w,
    input  logic [N_BITS-1:0]   cfg_out_h,
    input  logic [ADDR_W-1:0]   cfg_total,
    input  logic                in_valid,
    input  logic [N_BITS-1:0]   in_row,
    input  logic [N_BITS-1:0]   in_col,
    input  logic [7:0]          in_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_be,
    output logic                overflow,
    output logic                busy,
    output logic                done
`ifdef POOL_WB_BOUNDS_CHECK_EN
    ,
    output logic                oob_err
`endif
);

    localparam int SH_H = $clog2(FILTER_H);
    localparam int SH_W = $clog2(FILTER_W);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int WA   = ADDR_W - 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    generate
        if ((FILTER_H & (FILTER_H - 1)) != 0 || FILTER_H < 1)
            $error("FILTER_H must be a power of two");
        if ((FILTER_W & (FILTER_W - 1)) != 0 || FILTER_W < 1)
            $error("FILTER_W must be a power of two");
        if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2)
            $error("FIFO_DEPTH must be a power of two >= 2");
    endgenerate

    typedef struct packed {
        logic [WA-1:0] waddr;
        logic [1:0]    lane;
        logic [7:0]    data;
    } entry_t;

    function automatic logic [2:0] popcount4(input logic [3:0] b);
        return {2'b0, b[0]} + {2'b0, b[1]} + {2'b0, b[2]} + {2'b0, b[3]};
    endfunction

    // ---------------- stage 1: tag -> byte address ----------------
    logic [N_BITS-1:0] pr;
    logic [N_BITS-1:0] pc;
    logic [ADDR_W-1:0] byte_addr;
    logic              s1_accept;
    logic              s1_valid;
    entry_t            s1_entry;

    assign pr = in_row >> SH_H;
    assign pc = in_col >> SH_W;

    // Product taken modulo 2^ADDR_W; the address wraps by design.
    assign byte_addr = cfg_base_addr
                     + ADDR_W'(pr) * ADDR_W'(cfg_out_w)
                     + ADDR_W'(pc);

`ifdef POOL_WB_BOUNDS_CHECK_EN
    logic oob;
    assign oob       = (pr >= cfg_out_h) || (pc >= cfg_out_w);
    assign s1_accept = in_valid && !oob;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob_err <= 1'b0;
        end else if (start) begin
            oob_err <= 1'b0;
        end else if (in_valid && oob) begin
            oob_err <= 1'b1;
        end
    end
`else
    logic unused_cfg_h;
    assign unused_cfg_h = ^cfg_out_h;
    assign s1_accept    = in_valid;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else begin
            s1_valid <= s1_accept;
            if (s1_accept) begin
                s1_entry.waddr <= byte_addr[ADDR_W-1:2];
                s1_entry.lane  <= byte_addr[1:0];
                s1_entry.data  <= in_data;
            end
        end
    end

    // ---------------- entry FIFO ----------------
    entry_t        fifo_mem [FIFO_DEPTH];
    logic [PW:0]   wptr;
    logic [PW:0]   rptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    entry_t        head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) &&
                   (wptr[PW-1:0] == rptr[PW-1:0]);
    assign head  = fifo_mem[rptr[PW-1:0]];
    // A same-cycle pop frees the slot, so a push on full is still taken.
    assign push  = s1_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr[PW-1:0]] <= s1_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (start) begin
            overflow <= 1'b0;
        end else if (s1_valid && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // ---------------- coalescing FSM ----------------
    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [WA-1:0] pend_waddr;
    logic [3:0]    pend_be;
    logic [31:0]   pend_wdata;
    logic [3:0]    head_oh;
    logic [31:0]   head_word;
    logic          can_merge;
    logic          load;
    logic          merge;
    logic          hs;

    assign head_oh   = 4'b0001 << head.lane;
    assign head_word = 32'(head.data) << {head.lane, 3'b000};
    // A lane already present forces an issue; the colliding byte
    // then opens the next word instead of overwriting.
    assign can_merge = !empty && (head.waddr == pend_waddr) &&
                       ((pend_be & head_oh) == 4'b0);
    assign hs        = (state == S_ISSUE) && mem_req_ready;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        load    = 1'b0;
        merge   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (can_merge) begin
                    pop   = 1'b1;
                    merge = 1'b1;
                    if ((pend_be | head_oh) == 4'hF) begin
                        state_n = S_ISSUE;
                    end
                end else begin
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        state_n = S_ACCUM;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pend_waddr <= '0;
            pend_be    <= '0;
            pend_wdata <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                pend_waddr <= head.waddr;
                pend_be    <= head_oh;
                pend_wdata <= head_word;
            end else if (merge) begin
                pend_be    <= pend_be | head_oh;
                pend_wdata <= pend_wdata | head_word;
            end
        end
    end

    assign mem_req_valid = (state == S_ISSUE);
    assign mem_addr      = pend_waddr;
    assign mem_be        = pend_be;
    assign mem_wdata     = pend_wdata;
    assign busy          = s1_valid || !empty || (state != S_IDLE);

    // ---------------- written count / done ----------------
    // One extra bit so the count cannot wrap below a full-range total.
    logic [ADDR_W:0] wr_count;
    logic [ADDR_W:0] cnt_next;
    logic [ADDR_W:0] total_x;

    assign total_x  = {1'b0, cfg_total};
    assign cnt_next = wr_count + (ADDR_W+1)'(popcount4(pend_be));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            done     <= 1'b0;
        end else if (start) begin
            wr_count <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (hs) begin
                wr_count <= cnt_next;
                if (cfg_total != '0 && wr_count < total_x &&
                    cnt_next >= total_x) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_writeback.sv
// Directed bench for pool_writeback: address vectors plus
// coalescing, overflow, collision, wrap and bounds sequences.
module tb_pool_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] cfg_base_addr;
    logic [9:0]  cfg_out_w;
    logic [9:0]  cfg_out_h;
    logic [15:0] cfg_total;
    logic        in_valid;
    logic [9:0]  in_row;
    logic [9:0]  in_col;
    logic [7:0]  in_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        overflow;
    logic        busy;
    logic        done;
`ifdef POOL_WB_BOUNDS_CHECK_EN
    logic        oob_err;
`endif

    pool_writeback dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cfg_base_addr(cfg_base_addr),
        .cfg_out_w(cfg_out_w),
        .cfg_out_h(cfg_out_h),
        .cfg_total(cfg_total),
        .in_valid(in_valid),
        .in_row(in_row),
        .in_col(in_col),
        .in_data(in_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be(mem_be),
        .overflow(overflow),
        .busy(busy),
        .done(done)
`ifdef POOL_WB_BOUNDS_CHECK_EN
        ,
        .oob_err(oob_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } wr_t;

    typedef struct {
        logic [15:0] base;
        logic [9:0]  w;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [7:0]  data;
        logic [13:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    wr_t  hs_q[$];
    int   done_cnt;
    int   done_hs;
    int   checks;
    int   failures;
    vec_t vecs[6];

    // Handshake happens at the next posedge; inputs are stable here.
    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            hs_q.push_back('{addr: mem_addr, be: mem_be, wdata: mem_wdata});
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_hs  = hs_q.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [9:0] r, input logic [9:0] c,
                        input logic [7:0] d);
        in_valid = 1'b1;
        in_row   = r;
        in_col   = c;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((busy || mem_req_valid) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) begin
            checks++;
            failures++;
            $display("FAIL wait_idle actual=timeout required=idle");
        end
        tick();
        tick();
    endtask

    task automatic cfg(input logic [15:0] b, input logic [9:0] w,
                       input logic [15:0] t);
        cfg_base_addr = b;
        cfg_out_w     = w;
        cfg_out_h     = 10'd1023;
        cfg_total     = t;
    endtask

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        done_hs  = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_row   = '0;
        in_col   = '0;
        in_data  = '0;
        mem_req_ready = 1'b1;
        cfg(16'h0100, 10'd4, 16'd0);

        vecs[0] = '{16'h0100, 10'd4,   10'd0, 10'd0, 8'h05,
                    14'h0040, 4'b0001, 32'h0000_0005};
        vecs[1] = '{16'h0100, 10'd4,   10'd2, 10'd2, 8'h7F,
                    14'h0041, 4'b0010, 32'h0000_7F00};
        vecs[2] = '{16'hFFFE, 10'd4,   10'd0, 10'd4, 8'h80,
                    14'h0000, 4'b0001, 32'h0000_0080};
        vecs[3] = '{16'h0000, 10'd10,  10'd6, 10'd7, 8'hAA,
                    14'h0008, 4'b0010, 32'h0000_AA00};
        vecs[4] = '{16'h0203, 10'd4,   10'd1, 10'd1, 8'h11,
                    14'h0080, 4'b1000, 32'h1100_0000};
        vecs[5] = '{16'h1000, 10'd100, 10'd9, 10'd3, 8'hFF,
                    14'h0464, 4'b0010, 32'h0000_FF00};

        #2;
        tick();
        chk("rst_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_addr", {18'b0, mem_addr}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // single-sample address vectors with latency check
        for (int i = 0; i < 6; i++) begin
            cfg(vecs[i].base, vecs[i].w, 16'd0);
            hs_q.delete();
            send(vecs[i].row, vecs[i].col, vecs[i].data);
            lat = 1;
            while (!mem_req_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), lat, 4);
            chk($sformatf("v%0d_addr", i), {18'b0, mem_addr},
                {18'b0, vecs[i].exp_addr});
            chk($sformatf("v%0d_be", i), {28'b0, mem_be},
                {28'b0, vecs[i].exp_be});
            chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
            wait_idle(20);
            chk($sformatf("v%0d_nwrites", i), hs_q.size(), 1);
        end

        // two bytes of one word merge
        cfg(16'h0100, 10'd4, 16'd0);
        pulse_start();
        hs_q.delete();
        send(10'd0, 10'd0, 8'h05);
        send(10'd0, 10'd2, 8'hFD);
        wait_idle(20);
        chk("merge_nwrites", hs_q.size(), 1);
        if (hs_q.size() >= 1) begin
            chk("merge_addr", {18'b0, hs_q[0].addr}, 32'h40);
            chk("merge_be", {28'b0, hs_q[0].be}, 32'h3);
            chk("merge_wdata", hs_q[0].wdata, 32'h0000_FD05);
        end

        // four samples, two words, done on the second handshake
        cfg(16'h0100, 10'd4, 16'd4);
        pulse_start();
        hs_q.delete();
        done_cnt = 0;
        done_hs  = 0;
        send(10'd0, 10'd0, 8'h01);
        send(10'd0, 10'd2, 8'h02);
        send(10'd2, 10'd0, 8'h03);
        send(10'd2, 10'd2, 8'h04);
        wait_idle(30);
        chk("quad_nwrites", hs_q.size(), 2);
        if (hs_q.size() >= 2) begin
            chk("quad_addr0", {18'b0, hs_q[0].addr}, 32'h40);
            chk("quad_be0", {28'b0, hs_q[0].be}, 32'h3);
            chk("quad_wdata0", hs_q[0].wdata, 32'h0000_0201);
            chk("quad_addr1", {18'b0, hs_q[1].addr}, 32'h41);
            chk("quad_be1", {28'b0, hs_q[1].be}, 32'h3);
            chk("quad_wdata1", hs_q[1].wdata, 32'h0000_0403);
        end
        chk("quad_done_cnt", done_cnt, 1);
        chk("quad_done_at_hs", done_hs, 2);

        // stall: 12 distinct words, 9 survive, 3 dropped
        cfg(16'h0100, 10'd4, 16'd0);
        pulse_start();
        hs_q.delete();
        done_cnt = 0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send(10'(2 * i), 10'd0, 8'(i + 1));
            if (i == 6) begin
                chk("hold_valid_mid", {31'b0, mem_req_valid}, 32'd1);
                chk("hold_addr_mid", {18'b0, mem_addr}, 32'h40);
                chk("hold_be_mid", {28'b0, mem_be}, 32'h1);
            end
        end
        for (int i = 0; i < 8; i++) tick();
        chk("hold_valid_end", {31'b0, mem_req_valid}, 32'd1);
        chk("hold_addr_end", {18'b0, mem_addr}, 32'h40);
        chk("hold_be_end", {28'b0, mem_be}, 32'h1);
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        chk("ovf_busy", {31'b0, busy}, 32'd1);
        mem_req_ready = 1'b1;
        wait_idle(40);
        chk("ovf_nwrites", hs_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < hs_q.size()) begin
                chk($sformatf("ovf_addr%0d", i), {18'b0, hs_q[i].addr},
                    32'h40 + i);
                chk($sformatf("ovf_wdata%0d", i), hs_q[i].wdata, i + 1);
            end
        end
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);
        pulse_start();
        chk("ovf_cleared", {31'b0, overflow}, 32'd0);

        // lane collision: same coords twice, no merge; total 0 -> no done
        cfg(16'h0100, 10'd4, 16'd0);
        hs_q.delete();
        done_cnt = 0;
        send(10'd0, 10'd0, 8'h07);
        send(10'd0, 10'd0, 8'h08);
        wait_idle(20);
        chk("coll_nwrites", hs_q.size(), 2);
        if (hs_q.size() >= 2) begin
            chk("coll_addr0", {18'b0, hs_q[0].addr}, 32'h40);
            chk("coll_be0", {28'b0, hs_q[0].be}, 32'h1);
            chk("coll_wdata0", hs_q[0].wdata, 32'h07);
            chk("coll_addr1", {18'b0, hs_q[1].addr}, 32'h40);
            chk("coll_be1", {28'b0, hs_q[1].be}, 32'h1);
            chk("coll_wdata1", hs_q[1].wdata, 32'h08);
        end
        chk("total0_no_done", done_cnt, 0);

        // pooled col 4 on a width-4 plane
        cfg(16'h0100, 10'd4, 16'd0);
        cfg_out_h = 10'd4;
        hs_q.delete();
        send(10'd0, 10'd8, 8'h33);
        wait_idle(20);
`ifdef POOL_WB_BOUNDS_CHECK_EN
        chk("oob_nwrites", hs_q.size(), 0);
        chk("oob_err_set", {31'b0, oob_err}, 32'd1);
        pulse_start();
        chk("oob_err_clr", {31'b0, oob_err}, 32'd0);
`else
        chk("nochk_nwrites", hs_q.size(), 1);
        if (hs_q.size() >= 1) begin
            chk("nochk_addr", {18'b0, hs_q[0].addr}, 32'h41);
            chk("nochk_be", {28'b0, hs_q[0].be}, 32'h1);
            chk("nochk_wdata", hs_q[0].wdata, 32'h33);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
